btn_debounce: RTL and testbench
===============================

Name: btn_debounce

Overview:
- Conditions one raw push-button before it reaches the PIO edge-capture input, so one physical press gives exactly one clean rising edge.
- Synchronises the pad, normalises polarity and filters contact bounce with a stability counter.
- Outputs a clean level, one-cycle press and release strobes, and a one-cycle long-press strobe.
- btn_level drives the PIO in_port directly; the strobes are available to local logic.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new level (10 ms at 50 MHz); legal range 2 or more.
- LONG_CYCLES, 50000000, cycles btn_level must stay high before btn_long fires (1 s at 50 MHz); legal range 1 or more.
- ACTIVE_LOW, 1, 1 = pad reads 0 when pressed (board KEYs); 0 = pad reads 1 when pressed.
- CNT_W, 26, width of both internal counters; must hold max(DEBOUNCE_CYCLES, LONG_CYCLES).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- btn_raw  in  1  asynchronous button pad, unfiltered
- btn_level  out  1  debounced pressed level, 1 = pressed
- btn_press  out  1  one-cycle strobe on accepted press
- btn_release  out  1  one-cycle strobe on accepted release
- btn_long  out  1  one-cycle strobe once per press after the long hold time

Behaviour:
- Clock and reset: clk; reset_n is asynchronous, active-low. All flops reset asynchronously.
- Reset values: btn_level, btn_press, btn_release and btn_long = 0; both counters = 0.
- Reset values, synchroniser: both flops reset to the idle pad level, i.e. ACTIVE_LOW ? 1 : 0, so no event occurs after reset.
- Synchroniser: two-flop chain sync1 -> sync2. Only sync2 is used downstream.
- Normalised sample: s = ACTIVE_LOW ? ~sync2 : sync2.
- Debounce counter (db_cnt), evaluated every cycle:
  - s == btn_level: db_cnt <= 0.
  - s != btn_level and db_cnt == DEBOUNCE_CYCLES-1: btn_level <= s, db_cnt <= 0, and at the same edge btn_press <= s or btn_release <= ~s.
  - Otherwise: db_cnt <= db_cnt+1.
  - Net effect: a new level is accepted only after s has differed from btn_level for exactly DEBOUNCE_CYCLES consecutive cycles.
- Strobes: btn_press and btn_release are registered and high for exactly one cycle, in the first cycle btn_level shows its new value. They are default 0 every other cycle and are never high together.
- Latency: a clean pad edge shows on btn_level 2 + DEBOUNCE_CYCLES clock edges after the first sampling edge (±1 for synchroniser metastability).
- Bounce: any reversion of s before the threshold clears db_cnt. The accept window restarts, and no strobe or level change occurs.
- Long-press counter (hold_cnt), evaluated every cycle:
  - btn_level == 0: hold_cnt <= 0.
  - btn_level == 1 and hold_cnt < LONG_CYCLES: hold_cnt <= hold_cnt+1.
  - btn_long is high for one cycle on the edge where hold_cnt becomes LONG_CYCLES.
  - hold_cnt then saturates, so btn_long fires at most once per press.
  - btn_long timing: it is asserted LONG_CYCLES cycles after btn_level rises.
- Release before the long time: hold_cnt clears and no btn_long occurs. If release is accepted on the same edge btn_long would fire, btn_long still fires, because it is computed from the pre-edge btn_level.
- Counters never wrap. db_cnt stops at DEBOUNCE_CYCLES-1; hold_cnt saturates at LONG_CYCLES.
- Reset mid-press or mid-bounce: all state clears immediately. On release of reset the pad is re-evaluated from the idle level; a still-held button is accepted as a fresh press after 2 + DEBOUNCE_CYCLES cycles.
- Fully synchronous to clk apart from btn_raw; no combinational path from btn_raw to any output.

Test Plan (bench uses DEBOUNCE_CYCLES=8, LONG_CYCLES=32, ACTIVE_LOW=1):
1. Reset with btn_raw=1, then hold for 100 cycles -> all outputs 0 throughout; btn_press never asserts.
2. btn_raw driven 0 and held -> btn_level rises on edge 10 (±1) after the drive; btn_press high exactly that one cycle; btn_release stays 0.
3. Bounce: btn_raw 0 for 5 cycles, 1 for 2, 0 for 7, 1 for 3, then 0 steady -> no strobe until the steady run reaches 8 cycles; then exactly one btn_press.
4. Glitch while pressed: btn_raw 1 for 7 cycles -> btn_level stays 1, no btn_release; a 1 held for 8 or more cycles -> one btn_release and btn_level=0.
5. Hold pressed for 100 cycles -> btn_long one cycle, 32 cycles after btn_level rises, and never again; a press of only 20 cycles -> no btn_long.
6. Assert reset_n=0 for 3 cycles while pressed and stable, then release with btn_raw still 0 -> outputs 0 during reset; btn_press re-fires 10 (±1) cycles after reset deasserts.

Source files
------------

// File: rtl/btn_debounce_if.sv
// rtl/btn_debounce_if.sv - raw pad input and conditioned button outputs
interface btn_debounce_if;
    logic btn_raw;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic btn_long;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long
    );
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchroniser, bounce filter and press/release/long strobes
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int CNT_W           = 26
) (
    input  logic           clk,
    input  logic           reset_n,
    btn_debounce_if.slave  bus
);
    localparam logic             IDLE_PAD = ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] DB_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(LONG_CYCLES);

    logic             sync1;
    logic             sync2;
    logic             s;
    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic             btn_level;
    logic             btn_press;
    logic             btn_release;
    logic             btn_long;

    assign s = ACTIVE_LOW ? ~sync2 : sync2;

    assign bus.btn_level   = btn_level;
    assign bus.btn_press   = btn_press;
    assign bus.btn_release = btn_release;
    assign bus.btn_long    = btn_long;

    // Synchroniser resets to the idle pad level so reset release never looks like an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= IDLE_PAD;
            sync2 <= IDLE_PAD;
        end else begin
            sync1 <= bus.btn_raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_cnt      <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            if (s == btn_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_MAX) begin
                btn_level   <= s;
                db_cnt      <= '0;
                btn_press   <= s;
                btn_release <= ~s;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Uses the pre-edge level, so a release accepted on the firing edge still lets btn_long pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= '0;
            btn_long <= 1'b0;
        end else begin
            btn_long <= 1'b0;
            if (!btn_level) begin
                hold_cnt <= '0;
            end else if (hold_cnt < HOLD_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
                if (hold_cnt == HOLD_MAX - 1'b1) begin
                    btn_long <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - directed self-checking bench for btn_debounce
module tb_btn_debounce;
    localparam int DB = 8;
    localparam int LG = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    btn_debounce_if bif();

    btn_debounce #(
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LG),
        .ACTIVE_LOW     (1'b1),
        .CNT_W          (26)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bif.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_press = 0;
    int n_release = 0;
    int n_long = 0;
    int press_cyc = -1;
    int release_cyc = -1;
    int long_cyc = -1;
    int rise_cyc = -1;
    int t0 = 0;
    int long_before = 0;
    logic prev_level = 1'b0;
    bit both_seen = 1'b0;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bif.btn_press)   begin n_press++;   press_cyc = cyc;   end
            if (bif.btn_release) begin n_release++; release_cyc = cyc; end
            if (bif.btn_long)    begin n_long++;    long_cyc = cyc;    end
            if (bif.btn_press && bif.btn_release) both_seen = 1'b1;
            if (bif.btn_level && !prev_level) rise_cyc = cyc;
            prev_level = bif.btn_level;
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_level"},   int'(bif.btn_level),   0);
        check({tag, "_press"},   int'(bif.btn_press),   0);
        check({tag, "_release"}, int'(bif.btn_release), 0);
        check({tag, "_long"},    int'(bif.btn_long),    0);
    endtask

    initial begin
        // 1: reset with pad idle, then 100 idle cycles
        bif.btn_raw = 1'b1;
        tick(3);
        check_outputs_zero("t1_in_reset");
        reset_n = 1'b1;
        tick(100);
        check_outputs_zero("t1_idle");
        check("t1_press_count", n_press, 0);
        check("t1_release_count", n_release, 0);
        check("t1_long_count", n_long, 0);

        // 2: clean press, accepted on edge 10
        t0 = cyc;
        bif.btn_raw = 1'b0;
        tick(9);
        check("t2_level_before", int'(bif.btn_level), 0);
        tick(1);
        check("t2_level_after", int'(bif.btn_level), 1);
        check("t2_press_strobe", int'(bif.btn_press), 1);
        check("t2_press_latency", press_cyc - t0, 10);
        tick(1);
        check("t2_press_one_cycle", int'(bif.btn_press), 0);
        check("t2_press_count", n_press, 1);
        check("t2_release_count", n_release, 0);

        // 5a: long hold fires btn_long once, 32 cycles after the rise
        tick(98);
        check("t5_long_count", n_long, 1);
        check("t5_long_delay", long_cyc - rise_cyc, LG);

        // 4: 7-cycle glitch is rejected, 8+ cycle release is accepted
        bif.btn_raw = 1'b1;
        tick(7);
        bif.btn_raw = 1'b0;
        tick(20);
        check("t4_glitch_level", int'(bif.btn_level), 1);
        check("t4_glitch_release", n_release, 0);
        check("t4_long_once", n_long, 1);
        t0 = cyc;
        bif.btn_raw = 1'b1;
        tick(20);
        check("t4_release_count", n_release, 1);
        check("t4_release_latency", release_cyc - t0, 10);
        check("t4_level_low", int'(bif.btn_level), 0);

        // 5b: 20-cycle press gives no btn_long
        long_before = n_long;
        bif.btn_raw = 1'b0;
        tick(20);
        bif.btn_raw = 1'b1;
        tick(30);
        check("t5_short_press", n_press, 2);
        check("t5_short_release", n_release, 2);
        check("t5_short_no_long", n_long, long_before);

        // 3: bounce, only the final steady run is accepted
        n_press = 0;
        n_release = 0;
        bif.btn_raw = 1'b0; tick(5);
        bif.btn_raw = 1'b1; tick(2);
        bif.btn_raw = 1'b0; tick(7);
        bif.btn_raw = 1'b1; tick(3);
        check("t3_no_early_press", n_press, 0);
        check("t3_level_low", int'(bif.btn_level), 0);
        t0 = cyc;
        bif.btn_raw = 1'b0;
        tick(20);
        check("t3_press_count", n_press, 1);
        check("t3_press_latency", press_cyc - t0, 10);
        check("t3_release_count", n_release, 0);

        // 6: reset while pressed, held button re-accepted after reset
        reset_n = 1'b0;
        #1;
        check_outputs_zero("t6_reset_async");
        tick(3);
        check_outputs_zero("t6_in_reset");
        n_press = 0;
        reset_n = 1'b1;
        t0 = cyc;
        tick(9);
        check("t6_level_before", int'(bif.btn_level), 0);
        tick(1);
        check("t6_level_after", int'(bif.btn_level), 1);
        check("t6_press_latency", press_cyc - t0, 10);
        check("t6_press_count", n_press, 1);

        check("never_press_and_release", int'(both_seen), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
